// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Lets two requesters share one single-port MCU RAM. The RAM has an
// asynchronous read and a synchronous byte-masked write.
//   m0 : CPU data port
//   m1 : debug / loader port (UART boot, DMA)
//
// The arbiter grants at most one access per cycle, and the grant is
// combinational. The winner drives the RAM port in the same cycle. Read data
// is captured into one shared register, so requesters see it one cycle after
// a read grant. A requester can hold lock_i high to keep ownership across
// several accesses, for example a read-modify-write or a burst.
//
// Optional feature (compile-time macro):
//   RAM_ARB_RR_EN : round-robin arbitration in IDLE. On a conflict the master
//                   that was not granted last wins. Without the macro, m0
//                   always wins conflicts and no last-grant state exists.
//
// Parameters
//   ADDR_WIDTH : word address width (RAM depth is 2**ADDR_WIDTH)
//   DATA_WIDTH : word width, fixed at 32 (4 byte enables)
//
// Ports
//   clk_i                   system clock, rising edge
//   rst_i                   synchronous reset, active-high
//   m0_*/m1_* req_i         access request, held until granted
//             we_i          1 = write, 0 = read
//             addr_i        word address
//             wdata_i       write data
//             be_i          byte enables, bit k = byte k
//             lock_i        keep ownership after this access
//             gnt_o         access accepted this cycle (combinational)
//             rvalid_o      read data valid (cycle after read grant)
//             rdata_o       registered read data (shared register)
//   ram_addr_o / ram_din_o  RAM address / write data
//   ram_we_o                RAM write enable, high only with a write grant
//   ram_be_o                RAM byte enables
//   ram_dout_i              RAM asynchronous read data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      m0_req_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic                      m0_lock_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,

    input  logic                      m1_req_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic                      m1_lock_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,

    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_din_o,
    output logic                      ram_we_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0]     ram_dout_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e                  state_r;
    state_e                  state_nxt_s;

    logic                    gnt0_s;
    logic                    gnt1_s;
    logic                    acc_gnt_s;
    logic                    prefer_m1_s;

    logic                    win_we_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [DATA_WIDTH-1:0]   win_din_s;
    logic [BE_WIDTH-1:0]     win_be_s;

    logic [ADDR_WIDTH-1:0]   addr_hold_r;
    logic [DATA_WIDTH-1:0]   din_hold_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    rvalid0_r;
    logic                    rvalid1_r;

`ifdef RAM_ARB_RR_EN
    // Last-grant flag: 1 means m1 was granted most recently. It resets to m1
    // so that m0 wins the first conflict after reset.
    logic                    last_gnt_m1_r;

    // Track the most recent grant, including grants made while locked.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_m1_r <= 1'b1;
        end else if (gnt0_s) begin
            last_gnt_m1_r <= 1'b0;
        end else if (gnt1_s) begin
            last_gnt_m1_r <= 1'b1;
        end else begin
            last_gnt_m1_r <= last_gnt_m1_r;
        end
    end

    // On a conflict, prefer the master that was not granted last.
    assign prefer_m1_s = ~last_gnt_m1_r;
`else
    // Fixed priority: m0 always wins a conflict.
    assign prefer_m1_s = 1'b0;
`endif

    // Grant selection. In a locked state only the owner can be granted.
    // During reset nothing is granted, so no RAM write can occur.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst_i) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_req_i && m1_req_i) begin
                        if (prefer_m1_s) begin
                            gnt1_s = 1'b1;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = m0_req_i;
                        gnt1_s = m1_req_i;
                    end
                end
                ST_LOCK0: begin
                    gnt0_s = m0_req_i;
                end
                ST_LOCK1: begin
                    gnt1_s = m1_req_i;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Lock FSM. A granted access with lock_i=1 takes or keeps ownership.
    // A granted access with lock_i=0 releases it. An owner that stops
    // requesting keeps the lock indefinitely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt0_s && m0_lock_i) begin
                    state_nxt_s = ST_LOCK0;
                end else if (gnt1_s && m1_lock_i) begin
                    state_nxt_s = ST_LOCK1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK0: begin
                if (gnt0_s && !m0_lock_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK0;
                end
            end
            ST_LOCK1: begin
                if (gnt1_s && !m1_lock_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Select the winning master's access attributes.
    always_comb begin
        acc_gnt_s  = gnt0_s | gnt1_s;
        win_we_s   = m0_we_i;
        win_addr_s = m0_addr_i;
        win_din_s  = m0_wdata_i;
        win_be_s   = m0_be_i;
        if (gnt1_s) begin
            win_we_s   = m1_we_i;
            win_addr_s = m1_addr_i;
            win_din_s  = m1_wdata_i;
            win_be_s   = m1_be_i;
        end else begin
            win_we_s   = m0_we_i;
            win_addr_s = m0_addr_i;
            win_din_s  = m0_wdata_i;
            win_be_s   = m0_be_i;
        end
    end

    // Remember the last winner's address and data. When no access is
    // granted, the RAM address and data stay put and do not follow the
    // requesters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_hold_r <= {ADDR_WIDTH{1'b0}};
            din_hold_r  <= {DATA_WIDTH{1'b0}};
        end else if (acc_gnt_s) begin
            addr_hold_r <= win_addr_s;
            din_hold_r  <= win_din_s;
        end else begin
            addr_hold_r <= addr_hold_r;
            din_hold_r  <= din_hold_r;
        end
    end

    // Capture asynchronous RAM read data at the edge that ends a read grant.
    // The valid flag follows only the master that issued the read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= gnt0_s & ~m0_we_i;
            rvalid1_r <= gnt1_s & ~m1_we_i;
            if (acc_gnt_s && !win_we_s) begin
                rdata_r <= ram_dout_i;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // RAM port. The write enable and byte enables are active only with a
    // grant. A write with be=0 is granted but changes nothing.
    assign ram_we_o   = acc_gnt_s & win_we_s;
    assign ram_be_o   = acc_gnt_s ? win_be_s   : {BE_WIDTH{1'b0}};
    assign ram_addr_o = acc_gnt_s ? win_addr_s : addr_hold_r;
    assign ram_din_o  = acc_gnt_s ? win_din_s  : din_hold_r;

    assign m0_gnt_o    = gnt0_s;
    assign m1_gnt_o    = gnt1_s;
    assign m0_rvalid_o = rvalid0_r;
    assign m1_rvalid_o = rvalid1_r;
    assign m0_rdata_o  = rdata_r;
    assign m1_rdata_o  = rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps

module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
`ifdef RAM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    // Six cycles of simultaneous reads: fixed priority gives m0 all six;
    // round-robin alternates, starting with m0.
    localparam int T3_N0 = RR_MODE ? 3 : 6;
    localparam int T3_N1 = RR_MODE ? 3 : 0;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            m0_req_i = 1'b0, m0_we_i = 1'b0, m0_lock_i = 1'b0;
    logic [AW-1:0]   m0_addr_i = '0;
    logic [DW-1:0]   m0_wdata_i = '0;
    logic [3:0]      m0_be_i = 4'h0;
    logic            m1_req_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
    logic [AW-1:0]   m1_addr_i = '0;
    logic [DW-1:0]   m1_wdata_i = '0;
    logic [3:0]      m1_be_i = 4'h0;
    logic            m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0]   m0_rdata_o, m1_rdata_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_din_o;
    logic            ram_we_o;
    logic [3:0]      ram_be_o;
    logic [DW-1:0]   ram_dout_i;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i), .m0_lock_i(m0_lock_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i), .m1_lock_i(m1_lock_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_dout_i(ram_dout_i)
    );

    always #5 clk_i = ~clk_i;

    // The physical RAM the DUT drives (async read, sync byte-masked write).
    logic [DW-1:0] ram_mem [0:(1<<AW)-1] = '{default: '0};
    assign ram_dout_i = ram_mem[ram_addr_o];
    always @(posedge clk_i) begin
        if (ram_we_o) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_be_o[k]) ram_mem[ram_addr_o][8*k +: 8] <= ram_din_o[8*k +: 8];
            end
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the RAM, who was served last, what the
    // memory holds, and which read result is due next cycle.
    // ------------------------------------------------------------------
    logic [DW-1:0] model_mem [0:(1<<AW)-1] = '{default: '0};
    int            owner = -1;          // -1 none, 0/1 locked master
    int            last_m = 1;
    bit            pv0 = 1'b0, pv1 = 1'b0;
    logic [DW-1:0] pdata = '0;
    logic [AW-1:0] hold_addr = '0;
    logic [DW-1:0] hold_din = '0;
    bit            chk_en = 1'b0;

    function automatic int pick_winner();
        if (rst_i) return -1;
        if (owner == 0) return m0_req_i ? 0 : -1;
        if (owner == 1) return m1_req_i ? 1 : -1;
        if (m0_req_i && m1_req_i) return (RR_MODE && last_m == 0) ? 1 : 0;
        if (m0_req_i) return 0;
        if (m1_req_i) return 1;
        return -1;
    endfunction

    always @(negedge clk_i) begin : model_chk
        int            w;
        logic          w_we, w_lock;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_din;
        logic [3:0]    w_be;
        if (chk_en) begin
            w = pick_winner();
            if (w == 1) begin
                w_we = m1_we_i; w_lock = m1_lock_i; w_addr = m1_addr_i; w_din = m1_wdata_i; w_be = m1_be_i;
            end else begin
                w_we = m0_we_i; w_lock = m0_lock_i; w_addr = m0_addr_i; w_din = m0_wdata_i; w_be = m0_be_i;
            end
            chk("m0_gnt", m0_gnt_o, w == 0);
            chk("m1_gnt", m1_gnt_o, w == 1);
            chk("m0_rvalid", m0_rvalid_o, pv0);
            chk("m1_rvalid", m1_rvalid_o, pv1);
            if (pv0 || pv1) begin
                chk("m0_rdata", m0_rdata_o, pdata);
                chk("m1_rdata", m1_rdata_o, pdata);
            end
            if (w >= 0) begin
                chk("ram_we", ram_we_o, w_we);
                chk("ram_be", ram_be_o, w_be);
                chk("ram_addr", ram_addr_o, w_addr);
                chk("ram_din", ram_din_o, w_din);
            end else begin
                chk("ram_we_idle", ram_we_o, 1'b0);
                chk("ram_be_idle", ram_be_o, 4'h0);
                chk("ram_addr_hold", ram_addr_o, hold_addr);
                chk("ram_din_hold", ram_din_o, hold_din);
            end
            // Advance the model to the state after the coming rising edge.
            if (rst_i) begin
                owner = -1; last_m = 1; pv0 = 1'b0; pv1 = 1'b0;
                hold_addr = '0; hold_din = '0;
            end else begin
                pv0 = (w == 0) && !w_we;
                pv1 = (w == 1) && !w_we;
                if (w >= 0) begin
                    if (!w_we) pdata = model_mem[w_addr];
                    else begin
                        for (int k = 0; k < 4; k++)
                            if (w_be[k]) model_mem[w_addr][8*k +: 8] = w_din[8*k +: 8];
                    end
                    hold_addr = w_addr; hold_din = w_din; last_m = w;
                    owner = w_lock ? w : -1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input int m, input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] be, input bit lock);
        if (m == 0) begin
            m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = data; m0_be_i = be; m0_lock_i = lock;
        end else begin
            m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = data; m1_be_i = be; m1_lock_i = lock;
        end
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    // One access by master m; a read also returns the data seen with rvalid.
    task automatic do_acc(input int m, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] be, input bit lock, output logic [DW-1:0] rd);
        int waited = 0;
        bit got = 1'b0;
        rd = '0;
        drive(m, 1'b1, we, addr, data, be, lock);
        while (!got && waited < 20) begin
            @(negedge clk_i);
            if ((m == 0 && m0_gnt_o) || (m == 1 && m1_gnt_o)) got = 1'b1;
            else waited++;
            tick();
        end
        drive(m, 1'b0, 1'b0, addr, '0, 4'h0, 1'b0);
        chk("dir_grant_wait", got, 1'b1);
        if (got && !we) begin
            @(negedge clk_i);
            rd = m0_rdata_o;
            chk("dir_rvalid_own", (m == 0) ? m0_rvalid_o : m1_rvalid_o, 1'b1);
            chk("dir_rvalid_other", (m == 0) ? m1_rvalid_o : m0_rvalid_o, 1'b0);
            tick();
        end
    endtask

    task automatic rand_master(input int m, input bit granted);
        bit cur_req;
        cur_req = (m == 0) ? m0_req_i : m1_req_i;
        if (cur_req && !granted && $urandom_range(0, 19) != 0) begin
            // keep holding the pending request
        end else if ($urandom_range(0, 99) < 55) begin
            drive(m, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end else begin
            drive(m, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        int n0, n1, first, diff;
        bit g0, g1;

        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        // Reset state, hand-pinned.
        chk("rst_m0_gnt", m0_gnt_o, 1'b0);
        chk("rst_m1_gnt", m1_gnt_o, 1'b0);
        chk("rst_m0_rvalid", m0_rvalid_o, 1'b0);
        chk("rst_m1_rvalid", m1_rvalid_o, 1'b0);
        chk("rst_rdata", m0_rdata_o, 32'h0);
        chk("rst_ram_we", ram_we_o, 1'b0);
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;

        // 1: write then read at 0x010.
        do_acc(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        do_acc(0, 1'b0, 12'h010, 32'h0, 4'hF, 1'b0, rd);
        chk("t1_rdata", rd, 32'hDEADBEEF);

        // 2: byte-masked write from m1.
        do_acc(1, 1'b1, 12'h010, 32'h000000AA, 4'h1, 1'b0, rd);
        do_acc(1, 1'b0, 12'h010, 32'h0, 4'hF, 1'b0, rd);
        chk("t2_rdata", rd, 32'hDEADBEAA);

        // 6: read right after write; be=0 write leaves data alone.
        do_acc(0, 1'b1, 12'h030, 32'h11111111, 4'hF, 1'b0, rd);
        do_acc(0, 1'b0, 12'h030, 32'h0, 4'hF, 1'b0, rd);
        chk("t6_rdata", rd, 32'h11111111);
        do_acc(1, 1'b1, 12'h030, 32'hFFFFFFFF, 4'h0, 1'b0, rd);
        do_acc(1, 1'b0, 12'h030, 32'h0, 4'hF, 1'b0, rd);
        chk("t6_be0_rdata", rd, 32'h11111111);

        // 3: both request reads for six cycles after a fresh reset.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        drive(0, 1'b1, 1'b0, 12'h010, '0, 4'hF, 1'b0);
        drive(1, 1'b1, 1'b0, 12'h030, '0, 4'hF, 1'b0);
        n0 = 0; n1 = 0; first = -1;
        repeat (6) begin
            @(negedge clk_i);
            if (m0_gnt_o) begin n0++; if (first < 0) first = 0; end
            if (m1_gnt_o) begin n1++; if (first < 0) first = 1; end
            tick();
        end
        drive(0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        tick();
        chk("t3_m0_grants", n0, T3_N0);
        chk("t3_m1_grants", n1, T3_N1);
        chk("t3_first", first, 0);

        // 4: m1 locked read-modify-write on 0x020 while m0 waits.
        do_acc(0, 1'b1, 12'h020, 32'd5, 4'hF, 1'b0, rd);
        drive(1, 1'b1, 1'b0, 12'h020, '0, 4'hF, 1'b1);
        @(negedge clk_i);
        chk("t4_m1_lock_gnt", m1_gnt_o, 1'b1);
        tick();
        drive(1, 1'b0, 1'b0, 12'h020, '0, 4'h0, 1'b0);
        drive(0, 1'b1, 1'b0, 12'h021, '0, 4'hF, 1'b0);
        @(negedge clk_i);
        chk("t4_m0_blocked_idle", m0_gnt_o, 1'b0);
        chk("t4_rmw_rvalid", m1_rvalid_o, 1'b1);
        chk("t4_rmw_read", m1_rdata_o, 32'd5);
        rd = m1_rdata_o;
        tick();
        drive(1, 1'b1, 1'b1, 12'h020, rd + 32'd1, 4'hF, 1'b0);
        @(negedge clk_i);
        chk("t4_m0_blocked_wr", m0_gnt_o, 1'b0);
        chk("t4_m1_wr_gnt", m1_gnt_o, 1'b1);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        @(negedge clk_i);
        chk("t4_m0_after_unlock", m0_gnt_o, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        tick();
        do_acc(1, 1'b0, 12'h020, '0, 4'hF, 1'b0, rd);
        chk("t4_final", rd, 32'd6);

        // 5: reset while m0 holds the lock with a read outstanding.
        drive(0, 1'b1, 1'b0, 12'h010, '0, 4'hF, 1'b1);
        @(negedge clk_i);
        chk("t5_lock_gnt", m0_gnt_o, 1'b1);
        tick();
        drive(0, 1'b1, 1'b1, 12'h010, 32'hBAD0BAD0, 4'hF, 1'b1);
        drive(1, 1'b1, 1'b0, 12'h030, '0, 4'hF, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t5_no_gnt_in_rst", m0_gnt_o, 1'b0);
        chk("t5_no_we_in_rst", ram_we_o, 1'b0);
        tick();
        rst_i = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        @(negedge clk_i);
        chk("t5_rvalid_dropped", m0_rvalid_o, 1'b0);
        chk("t5_m1_immediate", m1_gnt_o, 1'b1);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        @(negedge clk_i);
        chk("t5_m1_rdata", m1_rdata_o, 32'h11111111);
        tick();
        do_acc(0, 1'b0, 12'h010, '0, 4'hF, 1'b0, rd);
        chk("t5_ram_unchanged", rd, 32'hDEADBEAA);

        // Randomized traffic on a small address window.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            g0 = m0_gnt_o; g1 = m1_gnt_o;
            tick();
            rst_i = ($urandom_range(0, 249) == 0);
            rand_master(0, g0);
            rand_master(1, g1);
        end
        rst_i = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
        repeat (3) tick();

        diff = 0;
        for (int i = 0; i < (1 << AW); i++) if (ram_mem[i] !== model_mem[i]) diff++;
        chk("mem_image_diffs", diff, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
